ped_crossing_ctrl: RTL and testbench



---
 rtl/ped_crossing_ctrl.sv | 157 +++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller fed by the vehicle light code: latches button requests,
// grants WALK at the start of red, then a flashing DON'T WALK clearance with countdown.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6,
    parameter int BLINK_HALF   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [7:0] countdown,
    output logic       fault
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [7:0]    WALK_LAST  = 8'(WALK_CYCLES);
    localparam logic [7:0]    FLASH_LOAD = 8'(FLASH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RED,
        ST_WALK,
        ST_FLASH,
        ST_FAULT
    } state_t;

    state_t        state, state_next;
    logic          s1, s2, s3;
    logic [2:0]    light_q;
    logic          req_next;
    logic [7:0]    walk_cnt, walk_cnt_next;
    logic [7:0]    countdown_next;
    logic [BW-1:0] blink_cnt, blink_cnt_next;
    logic          blink_on, blink_on_next;

    logic btn_rise;
    logic is_red;
    logic red_entry;
    logic illegal;

    assign btn_rise  = s2 & ~s3;
    assign is_red    = (light == 3'b100);
    assign red_entry = is_red && (light_q != 3'b100);
    assign illegal   = !((light == 3'b100) || (light == 3'b010) || (light == 3'b001));

    // Button synchronizer, light history and all controller state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            light_q     <= 3'b000;
            state       <= ST_IDLE;
            req_pending <= 1'b0;
            walk_cnt    <= 8'd0;
            countdown   <= 8'd0;
            blink_cnt   <= '0;
            blink_on    <= 1'b0;
        end else begin
            s1          <= ped_btn;
            s2          <= s1;
            s3          <= s2;
            light_q     <= light;
            state       <= state_next;
            req_pending <= req_next;
            walk_cnt    <= walk_cnt_next;
            countdown   <= countdown_next;
            blink_cnt   <= blink_cnt_next;
            blink_on    <= blink_on_next;
        end
    end

    // Next state; illegal light beats abort, abort beats timer expiry
    always_comb begin
        state_next     = state;
        req_next       = req_pending;
        walk_cnt_next  = walk_cnt;
        countdown_next = countdown;
        blink_cnt_next = blink_cnt;
        blink_on_next  = blink_on;

        if (btn_rise && ((state == ST_IDLE) || (state == ST_WAIT_RED) || (state == ST_FLASH)))
            req_next = 1'b1;

        if (illegal) begin
            state_next     = ST_FAULT;
            countdown_next = 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_pending)
                        state_next = ST_WAIT_RED;
                end
                ST_WAIT_RED: begin
                    if (red_entry) begin
                        state_next    = ST_WALK;
                        req_next      = 1'b0;
                        walk_cnt_next = 8'd1;
                    end
                end
                ST_WALK: begin
                    if (!is_red) begin
                        state_next     = req_pending ? ST_WAIT_RED : ST_IDLE;
                        countdown_next = 8'd0;
                    end else if (walk_cnt == WALK_LAST) begin
                        state_next     = ST_FLASH;
                        countdown_next = FLASH_LOAD;
                        blink_cnt_next = '0;
                        blink_on_next  = 1'b1;
                    end else begin
                        walk_cnt_next = walk_cnt + 8'd1;
                    end
                end
                ST_FLASH: begin
                    if (!is_red) begin
                        state_next     = req_pending ? ST_WAIT_RED : ST_IDLE;
                        countdown_next = 8'd0;
                    end else begin
                        countdown_next = countdown - 8'd1;
                        if (countdown == 8'd1)
                            state_next = req_pending ? ST_WAIT_RED : ST_IDLE;
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_next = '0;
                            blink_on_next  = ~blink_on;
                        end else begin
                            blink_cnt_next = blink_cnt + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next     = ST_IDLE;
                    countdown_next = 8'd0;
                end
            endcase
        end
    end

    // Lamps follow the state; DON'T WALK is solid everywhere except WALK and FLASH
    always_comb begin
        walk      = (state == ST_WALK);
        fault     = (state == ST_FAULT);
        dont_walk = 1'b1;
        if (state == ST_WALK)
            dont_walk = 1'b0;
        else if (state == ST_FLASH)
            dont_walk = blink_on;
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Randomized bench for ped_crossing_ctrl, checked every cycle against a phase/elapsed-time
// reference model of the crossing rules.
module tb_ped_crossing_ctrl;

    localparam int WALK_CYCLES  = 8;
    localparam int FLASH_CYCLES = 6;
    localparam int BLINK_HALF   = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [2:0] light   = 3'b001;
    logic       ped_btn = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [7:0] countdown;
    logic       fault;

    int   total     = 0;
    int   bad       = 0;
    int   walk_seen = 0;
    logic btn_level = 1'b0;

    typedef enum {M_IDLE, M_WAIT, M_WALK, M_FLASH, M_FAULT} mode_t;
    mode_t      m_mode;
    int         m_t;
    logic       m_pending;
    logic [2:0] m_prev_light;
    bit         m_hist[$];

    logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    ped_crossing_ctrl #(
        .WALK_CYCLES (WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light      (light),
        .ped_btn    (ped_btn),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .countdown  (countdown),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode       = M_IDLE;
        m_t          = 0;
        m_pending    = 1'b0;
        m_prev_light = 3'b000;
        m_hist       = '{1'b0, 1'b0, 1'b0};
    endtask

    // One clock edge of the crossing rules, using the values present before the edge
    task automatic modelStep();
        bit   rise;
        bit   red_now;
        bit   red_entry;
        bit   illegal;
        logic next_pending;
        rise      = m_hist[1] && !m_hist[2];
        red_now   = (light == 3'b100);
        red_entry = red_now && (m_prev_light != 3'b100);
        illegal   = !((light == 3'b100) || (light == 3'b010) || (light == 3'b001));
        next_pending = m_pending;
        if (rise && (m_mode == M_IDLE || m_mode == M_WAIT || m_mode == M_FLASH))
            next_pending = 1'b1;
        if (illegal) begin
            m_mode = M_FAULT;
        end else begin
            case (m_mode)
                M_IDLE: if (m_pending) m_mode = M_WAIT;
                M_WAIT: if (red_entry) begin
                    m_mode       = M_WALK;
                    m_t          = 0;
                    next_pending = 1'b0;
                end
                M_WALK: begin
                    if (!red_now) m_mode = m_pending ? M_WAIT : M_IDLE;
                    else if (m_t + 1 == WALK_CYCLES) begin
                        m_mode = M_FLASH;
                        m_t    = 0;
                    end else m_t++;
                end
                M_FLASH: begin
                    if (!red_now || (m_t + 1 == FLASH_CYCLES)) m_mode = m_pending ? M_WAIT : M_IDLE;
                    else m_t++;
                end
                default: m_mode = M_FAULT;
            endcase
        end
        m_pending = next_pending;
        m_hist.push_front(ped_btn);
        void'(m_hist.pop_back());
        m_prev_light = light;
    endtask

    task automatic checkAll(input string tag);
        logic       exp_walk;
        logic       exp_dw;
        logic [7:0] exp_cd;
        exp_walk = (m_mode == M_WALK);
        exp_dw   = (m_mode == M_FLASH) ? (((m_t / BLINK_HALF) % 2) == 0) : (m_mode != M_WALK);
        exp_cd   = (m_mode == M_FLASH) ? 8'(FLASH_CYCLES - m_t) : 8'd0;
        checkOutput({tag, ".walk"},      {7'd0, walk},        {7'd0, exp_walk});
        checkOutput({tag, ".dont_walk"}, {7'd0, dont_walk},   {7'd0, exp_dw});
        checkOutput({tag, ".req"},       {7'd0, req_pending}, {7'd0, m_pending});
        checkOutput({tag, ".countdown"}, countdown,           exp_cd);
        checkOutput({tag, ".fault"},     {7'd0, fault},       {7'd0, (m_mode == M_FAULT)});
        if (walk === 1'b1) walk_seen++;
    endtask

    task automatic applyStimulus(input logic [2:0] l, input logic b);
        @(negedge clk);
        checkAll("cyc");
        light   = l;
        ped_btn = b;
        @(posedge clk);
        modelStep();
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) applyStimulus(l, btn_level);
    endtask

    task automatic runRandom(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) btn_level = ~btn_level;
            applyStimulus(l, btn_level);
        end
    endtask

    // Asserted between clock edges so the async clear is observed without a clock
    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkAll("reset");
        light     = 3'b001;
        ped_btn   = 1'b0;
        btn_level = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelStep();
    endtask

    task automatic pressIn(input logic [2:0] l);
        btn_level = 1'b1;
        run(l, 3);
        btn_level = 1'b0;
        run(l, 3);
    endtask

    initial begin
        modelReset();
        doReset();

        $display("[TB] legal light cycling, no button");
        for (int k = 0; k < 2; k++) begin
            run(3'b001, 5); run(3'b010, 2); run(3'b100, 12);
        end

        $display("[TB] press in green, long red");
        walk_seen = 0;
        run(3'b001, 3);
        pressIn(3'b001);
        run(3'b010, 2);
        run(3'b100, 30);
        checkOutput("walk_len", 8'(walk_seen), 8'(WALK_CYCLES));

        $display("[TB] press mid-red waits for next red");
        run(3'b001, 3); run(3'b010, 2); run(3'b100, 4);
        pressIn(3'b100);
        run(3'b100, 10); run(3'b001, 4); run(3'b010, 2); run(3'b100, 25);

        $display("[TB] red ends during WALK");
        pressIn(3'b001);
        run(3'b010, 2); run(3'b100, 4); run(3'b001, 5);

        $display("[TB] press during WALK and during FLASH");
        pressIn(3'b001);
        run(3'b010, 2); run(3'b100, 3);
        btn_level = 1'b1; run(3'b100, 2);
        btn_level = 1'b0; run(3'b100, 6);
        btn_level = 1'b1; run(3'b100, 2);
        btn_level = 1'b0; run(3'b100, 15);
        run(3'b001, 4); run(3'b010, 2); run(3'b100, 20);

        $display("[TB] illegal light is sticky");
        run(3'b001, 3); run(3'b110, 1); run(3'b001, 3);
        pressIn(3'b001);
        run(3'b010, 2); run(3'b100, 12);
        doReset();

        $display("[TB] async reset during WALK");
        pressIn(3'b001);
        run(3'b010, 2); run(3'b100, 4);
        doReset();

        $display("[TB] randomized traffic");
        for (int seg = 0; seg < 40; seg++) begin
            runRandom(3'b001, $urandom_range(2, 6));
            runRandom(3'b010, 2);
            runRandom(3'b100, $urandom_range(3, 26));
            if ($urandom_range(0, 9) == 0) begin
                runRandom(bad_codes[$urandom_range(0, 4)], 1);
                runRandom(3'b001, 4);
                doReset();
            end else if ($urandom_range(0, 14) == 0) begin
                doReset();
            end
        end

        @(negedge clk);
        checkAll("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
